riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit, parametrised in datapath width; attaches to the pipeline EX stage beside the ALU.
- Accepts one operation per start pulse and holds the pipeline via busy.
- Returns one DATA_W result with a single-cycle done pulse.
- Implements full RISC-V M semantics: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, including divide-by-zero and signed overflow.

Parameters:
DATA_W, 32, operand/result width; even, >= 8 (32 for RV32, 64 for RV64)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (unit in reset while 0)
start  input  1  operation request; sampled only when busy=0
flush  input  1  pipeline flush; aborts any operation in flight
funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_W  rs1 value (multiplicand / dividend)
op_b  input  DATA_W  rs2 value (multiplier / divisor)
busy  output  1  operation in progress; stall request to hazard logic
done  output  1  one-cycle pulse; result valid
result  output  DATA_W  operation result; held until the next accepted start

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (reset=0): state IDLE, busy=0, done=0, result=0, all internal registers 0.
- busy=1 exactly in CALC and FIX. done=1 exactly in DONE.
- Accept: start=1 in IDLE or DONE. funct3/op_a/op_b are latched on the accepting edge. start is ignored in CALC and FIX. No queueing.
- Cycle 0 is the accept cycle.
  - Normal path: CALC cycles 1..DATA_W (one radix-2 step per cycle), FIX cycle DATA_W+1, DONE cycle DATA_W+2.
  - Latency for DATA_W=32 is 34 cycles from accept to done.
- Multiply:
  - Signed operands are converted to magnitudes at accept. MUL and MULH treat both signed. MULHSU treats op_a signed, op_b unsigned. MULHU treats both unsigned.
  - CALC performs a shift-add into a 2*DATA_W accumulator.
  - FIX negates the product if the operand signs differ.
  - MUL returns the low DATA_W bits; MULH* return the high DATA_W bits.
- Divide:
  - Restoring divide on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - FIX applies signs: quotient is negative iff the signs differ; remainder takes the dividend's sign.
- Early-out path, IDLE/DONE -> DONE directly with done in cycle 1 and busy never asserted:
  - Divisor 0: quotient = all ones; remainder = op_a.
  - Signed overflow (DIV/REM, op_a = 1<<(DATA_W-1), op_b = all ones): quotient = op_a; remainder = 0.
- DONE with start=0 goes to IDLE next cycle. DONE with start=1 accepts back-to-back.
- flush=1 in any state: next state IDLE, done=0, result unchanged. flush takes priority over start in the same cycle.
- reset asserted mid-operation: immediate return to reset values; no done is produced.
- Iteration counter width is $clog2(DATA_W)+1. It never wraps; CALC exits when the count reaches DATA_W.

Optional Feature:
RISCV_MULDIV_FASTMUL_EN:
- Defined:
  - Multiply ops compute the full 2*DATA_W signed/unsigned product combinationally at accept.
  - They go IDLE/DONE -> DONE with done in cycle 1 and busy never asserted.
  - Divide ops are unchanged.
- Undefined:
  - Multiply uses the iterative path (done in cycle DATA_W+2).
- Results are bit-identical in both builds.

Decomposition:
- Package riscv_muldiv_pkg:
  - muldiv_op_e enum for the funct3 encodings.
  - muldiv_state_e enum (IDLE, CALC, FIX, DONE).
  - Functions abs_val and neg_val, parametrised via DATA_W-sized logic.
- No sub-module is natural: the unit is one FSM plus a shared accumulator/shift register, kept in a single module.

Test Plan:
- MUL 7 x -3 (DATA_W=32) -> done in cycle 34 (cycle 1 if FASTMUL), result 0xFFFFFFEB. MULH of the same -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. Each done in cycle 34, busy high in cycles 1..33.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both done in cycle 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, both done in cycle 1.
- Back-to-back: start held high in the DONE cycle of DIVU 100/7 with new op MULHSU -1 x 2 -> first result 14, second result 0xFFFFFFFF. Exactly two done pulses; start pulses during busy are ignored.
- flush in cycle 10 of a DIV -> IDLE next cycle, no done, result keeps its prior value. flush and start in the same IDLE cycle -> not accepted.
- reset driven low in cycle 20 of a MUL -> busy=0, done=0, result=0 immediately. After release, a new MUL 3 x 4 -> 12.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_pkg
// Description : Shared types and helpers for the RISC-V M-extension
//               multiply/divide unit: funct3 operation encodings, FSM state
//               encoding and two's-complement sign helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_muldiv_pkg;

    // Helpers work on a fixed wide vector; callers zero-extend their
    // operands in and size-cast the result back to their own width.
    // 128 bits covers the 2*DATA_W product of an RV64 build.
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Two's-complement negation; the low N bits are the N-bit negation.
    function automatic logic [MAX_W-1:0] neg_val(input logic [MAX_W-1:0] x);
        return -x;
    endfunction

    // Magnitude of a value whose sign has already been extracted by the
    // caller (neg = 1 means the N-bit operand was negative).
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input logic             neg);
        return neg ? neg_val(x) : x;
    endfunction

endpackage : riscv_muldiv_pkg
`default_nettype wire

// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit. One radix-2
//               shift-add (multiply) or restoring-divide step per cycle on
//               operand magnitudes, followed by a sign fix-up cycle.
//               Divide-by-zero and signed overflow finish in one cycle.
// Config      : `define RISCV_MULDIV_FASTMUL_EN for a single-cycle
//               combinational multiplier (divide stays iterative).
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-low reset
//               start  - operation request, sampled when not busy
//               flush  - abort operation in flight (wins over start)
//               funct3 - M-extension operation select
//               op_a   - rs1 (multiplicand / dividend)
//               op_b   - rs2 (multiplier / divisor)
//               busy   - operation in progress (CALC/FIX)
//               done   - one-cycle result-valid pulse
//               result - result, held until the next completion
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

    muldiv_state_e     state_q;
    muldiv_op_e        op_q;
    logic              qneg_q;     // negate product / quotient in FIX
    logic              rneg_q;     // negate remainder in FIX
    logic [PW-1:0]     acc_q;      // {remainder|prod_hi, quotient|multiplier}
    logic [DATA_W-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;

    // ------------------------------------------------------------------
    // Accept-time decode: operand signs, magnitudes and early-out results
    // ------------------------------------------------------------------
    muldiv_op_e        op_in;
    logic              is_div, a_signed, b_signed, sa, sb;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              div_zero, div_ovf, early;
    logic [DATA_W-1:0] early_res_d;
`ifdef RISCV_MULDIV_FASTMUL_EN
    logic [PW-1:0]     fast_mag, fast_prod;
`endif

    always_comb begin
        op_in    = muldiv_op_e'(funct3);
        is_div   = funct3[2];
        a_signed = !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
        b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa       = a_signed & op_a[DATA_W-1];
        sb       = b_signed & op_b[DATA_W-1];
        a_mag    = DATA_W'(abs_val(MAX_W'(op_a), sa));
        b_mag    = DATA_W'(abs_val(MAX_W'(op_b), sb));
        div_zero = (op_b == '0);
        div_ovf  = b_signed && (op_a == MIN_INT) && (op_b == '1);
        early    = is_div && (div_zero || div_ovf);
        early_res_d = '0;
        if (div_zero) begin
            // funct3[1] selects remainder
            early_res_d = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            early_res_d = funct3[1] ? '0 : op_a;
        end
`ifdef RISCV_MULDIV_FASTMUL_EN
        fast_mag  = PW'(a_mag) * PW'(b_mag);
        fast_prod = PW'(abs_val(MAX_W'(fast_mag), sa ^ sb));
        if (!is_div) begin
            early       = 1'b1;
            early_res_d = (op_in == OP_MUL) ? fast_prod[DATA_W-1:0]
                                            : fast_prod[PW-1:DATA_W];
        end
`else
        fast_unused_guard();
`endif
    end

`ifndef RISCV_MULDIV_FASTMUL_EN
    function automatic void fast_unused_guard();
    endfunction
`endif

    // ------------------------------------------------------------------
    // Iteration step and sign fix-up
    // ------------------------------------------------------------------
    logic [DATA_W:0]   add_sum, trial;
    logic [PW-1:0]     acc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [PW-1:0]     prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix, result_d;

    always_comb begin
        add_sum = {1'b0, acc_q[PW-1:DATA_W]} + {1'b0, opnd_q};
        // Shifted partial remainder needs DATA_W+1 bits; MSB of the
        // difference set means the trial subtraction borrowed.
        trial   = acc_q[PW-1:DATA_W-1] - {1'b0, opnd_q};
        if (op_q[2]) begin
            acc_d = trial[DATA_W] ? {acc_q[PW-2:0], 1'b0}
                                  : {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = acc_q[0] ? {add_sum, acc_q[DATA_W-1:1]}
                             : {1'b0, acc_q[PW-1:1]};
        end
        cnt_d    = cnt_q + CNT_W'(1);

        prod_fix = PW'(abs_val(MAX_W'(acc_q), qneg_q));
        quo_fix  = DATA_W'(abs_val(MAX_W'(acc_q[DATA_W-1:0]), qneg_q));
        rem_fix  = DATA_W'(abs_val(MAX_W'(acc_q[PW-1:DATA_W]), rneg_q));
        case (op_q)
            OP_MUL:                      result_d = prod_fix[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[PW-1:DATA_W];
            OP_DIV, OP_DIVU:             result_d = quo_fix;
            default:                     result_d = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        op_q   <= op_in;
                        qneg_q <= sa ^ sb;
                        rneg_q <= sa;
                        cnt_q  <= '0;
                        if (early) begin
                            result_q <= early_res_d;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            // Divide shifts the dividend out of the low half;
                            // multiply shifts the multiplier out of it.
                            acc_q   <= {{DATA_W{1'b0}}, is_div ? a_mag : b_mag};
                            opnd_q  <= is_div ? b_mag : a_mag;
                            busy_q  <= 1'b1;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_W'(DATA_W)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : riscv_muldiv_unit
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed scoreboard bench for riscv_muldiv_unit (DATA_W=32).
//               Stimulus pushes expected result and completion cycle; a
//               monitor pops on every done pulse and compares.
// Config      : honours RISCV_MULDIV_FASTMUL_EN for multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

    localparam int W = 32;
`ifdef RISCV_MULDIV_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.DATA_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    string        q_name[$];
    logic [W-1:0] q_res[$];
    int           q_due[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [W-1:0] r, input int due);
        q_name.push_back(nm);
        q_res.push_back(r);
        q_due.push_back(due);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        string        nm;
        logic [W-1:0] r;
        int           d;
        if (reset && done) begin
            if (q_res.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with result 0x%08h, expected no done", result);
            end else begin
                nm = q_name.pop_front();
                r  = q_res.pop_front();
                d  = q_due.pop_front();
                chk({nm, "_result"}, result, r);
                chk({nm, "_cycle"}, W'(cyc), W'(d));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                         output int acc);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        acc    = cyc;
        push(nm, exp, acc + lat);
    endtask

    // Busy must be high exactly in cycles 1..lat-1 of an iterative op.
    task automatic wait_done(input string nm, input int acc, input int lat);
        int  k;
        bit  bexp;
        step();
        start = 1'b0;
        for (int i = 0; i < lat + 8; i++) begin
            k    = cyc - acc;
            bexp = (lat > 1) && (k >= 1) && (k <= lat - 1);
            chk({nm, "_busy"}, W'(busy), W'(bexp));
            if (q_res.size() == 0) break;
            step();
        end
        if (q_res.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done by cycle %0d, expected done", nm, cyc - acc);
            q_name.delete();
            q_res.delete();
            q_due.delete();
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int acc;
        issue(nm, f, a, b, exp, lat, acc);
        wait_done(nm, acc, lat);
        step();
        chk({nm, "_idle_done"}, W'(done), '0);
    endtask

    initial begin
        int           acc;
        logic [W-1:0] prior;

        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           acc;
        logic [W-1:0] prior;

        repeat (3) step();
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_result", result, '0);
        reset = 1'b1;
        step();

        // Multiply family
        run_op("mul_7x-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh_7x-3",    3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT);
        run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        // Divide family
        run_op("div_-7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        run_op("rem_-7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        run_op("divu_100/7",   3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("remu_100/7",   3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("divu_min/max", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT);
        // Early-out cases
        run_op("divu_5/0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5/0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Back-to-back with ignored starts while busy
        issue("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, acc);
        step();
        start = 1'b0;
        while (cyc - acc < DIV_LAT) begin
            if ((cyc - acc == 5) || (cyc - acc == 20)) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op_a   = 32'd9;
                op_b   = 32'd9;
            end else begin
                start = 1'b0;
            end
            step();
        end
        chk("b2b_done_cycle_done", W'(done), 32'd1);
        begin
            int acc2;
            issue("b2b_mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT, acc2);
            wait_done("b2b_mulhsu", acc2, MUL_LAT);
        end
        step();
        prior = 32'hFFFFFFFF;

        // Flush in cycle 10 of a DIV
        start  = 1'b1;
        funct3 = 3'b100;
        op_a   = 32'hFFFFFFF9;
        op_b   = 32'd2;
        acc    = cyc;
        step();
        start = 1'b0;
        while (cyc - acc < 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", W'(busy), '0);
        chk("flush_done", W'(done), '0);
        chk("flush_result", result, prior);
        repeat (40) step();
        chk("flush_result_later", result, prior);

        // Flush and start together in IDLE
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", W'(busy), '0);
        repeat (40) step();
        chk("flush_start_result", result, prior);

        // Asynchronous reset in cycle 20 of a MUL
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd6;
        acc    = cyc;
`ifdef RISCV_MULDIV_FASTMUL_EN
        push("rst_mul", 32'd30, acc + 1);
`endif
        step();
        start = 1'b0;
        while (cyc - acc < 20) step();
        reset = 1'b0;
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        step();
        reset = 1'b1;
        step();
        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);

        repeat (3) step();
        if (q_res.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover: got %0d pending results, expected 0", q_res.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_riscv_muldiv_unit
`default_nettype wire
